// File: rtl/sound_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : sound_out_stage
// Brief    : Decimating sample-and-hold of the mixed stereo stream, master
//            gain/mute with saturation, small show-ahead FIFO toward the codec.
// Revision : 1.0
// ============================================================================
module sound_out_stage #(
    parameter int FIFO_AW        = 2,
    parameter int DEFAULT_PERIOD = 1042,
    parameter int DEFAULT_GAIN   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic [8:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        overflow
);

    localparam int         c_depth       = 1 << FIFO_AW;
    localparam logic [8:0] c_addr_period = 9'd258;
    localparam logic [8:0] c_addr_gain   = 9'd259;
    localparam logic [8:0] c_addr_clear  = 9'd260;

    logic [10:0]        r_period;
    logic [10:0]        r_cnt;
    logic [7:0]         r_gain_l;
    logic [7:0]         r_gain_r;
    logic               r_mute;
    logic               r_overflow;
    logic               r_v1;
    logic               r_v2;
    logic signed [15:0] r_s1_l;
    logic signed [15:0] r_s1_r;
    logic signed [24:0] r_p_l;
    logic signed [24:0] r_p_r;
    logic [31:0]        r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [31:0]        r_hold;

    logic        w_tick;
    logic        w_wr_period;
    logic        w_wr_gain;
    logic        w_wr_clear;
    logic [10:0] w_new_period;
    logic [15:0] w_q_l;
    logic [15:0] w_q_r;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [31:0] w_head;
    logic        w_unused_bits;

    // Floor-shift by 7 (gain 128 = unity) then clamp to the 16-bit signed range.
    function automatic logic [15:0] saturate(input logic signed [24:0] p);
        logic signed [24:0] s;
        s = p >>> 7;
        if (s > 25'sd32767)
            return 16'h7FFF;
        else if (s < -25'sd32768)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

    assign w_tick        = (r_cnt == (r_period - 11'd1));
    assign w_wr_period   = mgmt_write && (mgmt_address == c_addr_period);
    assign w_wr_gain     = mgmt_write && (mgmt_address == c_addr_gain);
    assign w_wr_clear    = mgmt_write && (mgmt_address == c_addr_clear);
    assign w_new_period  = (mgmt_writedata[10:0] < 11'd2) ? 11'd2 : mgmt_writedata[10:0];
    assign w_unused_bits = &{1'b0, mgmt_writedata[31:17]};

    assign w_q_l = r_mute ? 16'h0000 : saturate(r_p_l);
    assign w_q_r = r_mute ? 16'h0000 : saturate(r_p_r);

    // Count never exceeds the depth, so its MSB alone marks full.
    assign w_empty = (r_count == '0);
    assign w_full  = r_count[FIFO_AW];
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = r_v2 && (!w_full || w_pop);
    assign w_drop  = r_v2 && w_full && !w_pop;
    assign w_head  = r_mem[r_rptr];

    assign out_valid = !w_empty;
    assign out_l     = w_empty ? r_hold[31:16] : w_head[31:16];
    assign out_r     = w_empty ? r_hold[15:0]  : w_head[15:0];
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period   <= 11'(DEFAULT_PERIOD);
            r_cnt      <= '0;
            r_gain_l   <= 8'(DEFAULT_GAIN);
            r_gain_r   <= 8'(DEFAULT_GAIN);
            r_mute     <= 1'b0;
            r_overflow <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_s1_l     <= '0;
            r_s1_r     <= '0;
            r_p_l      <= '0;
            r_p_r      <= '0;
        end else begin
            if (w_wr_period) begin
                r_period <= w_new_period;
                r_cnt    <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 11'd1;
            end

            if (w_wr_gain) begin
                r_gain_l <= mgmt_writedata[7:0];
                r_gain_r <= mgmt_writedata[15:8];
                r_mute   <= mgmt_writedata[16];
            end

            if (w_drop)
                r_overflow <= 1'b1;
            else if (w_wr_clear)
                r_overflow <= 1'b0;

            r_v1 <= w_tick;
            if (w_tick) begin
                r_s1_l <= sample_l;
                r_s1_r <= sample_r;
            end
            r_v2  <= r_v1;
            r_p_l <= 25'(r_s1_l) * 25'($signed({1'b0, r_gain_l}));
            r_p_r <= 25'(r_s1_r) * 25'($signed({1'b0, r_gain_r}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_hold <= w_head;
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {w_q_l, w_q_r};
    end

endmodule
`default_nettype wire

// File: tb/tb_sound_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_out_stage
// Brief    : Randomized scoreboard bench for sound_out_stage against a
//            cycle-level arithmetic reference of decimation, gain and FIFO.
// Revision : 1.0
// ============================================================================
module tb_sound_out_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic [8:0]  mgmt_address = '0;
    logic        mgmt_write = 1'b0;
    logic [31:0] mgmt_writedata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        overflow;

    always #5 clk = ~clk;

    sound_out_stage #(
        .FIFO_AW        (2),
        .DEFAULT_PERIOD (1042),
        .DEFAULT_GAIN   (128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_l       (sample_l),
        .sample_r       (sample_r),
        .mgmt_address   (mgmt_address),
        .mgmt_write     (mgmt_write),
        .mgmt_writedata (mgmt_writedata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_l          (out_l),
        .out_r          (out_r),
        .overflow       (overflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    int m_cnt, m_per, m_gl, m_gr, m_s1l, m_s1r, m_p2l, m_p2r;
    bit m_mute, m_ovf, m_v1, m_v2;

    function automatic logic [15:0] ref_out(int p, bit mute);
        int q;
        if (mute) return 16'h0000;
        q = (p >= 0) ? p / 128 : -((-p + 127) / 128);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts at each falling edge what the next rising edge does.
    always @(negedge clk) begin
        int          sz;
        bit          pop;
        bit          tick;
        bit          drop;
        logic [31:0] head;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = 0; m_per = 1042; m_gl = 128; m_gr = 128;
            m_mute = 0; m_ovf = 0; m_v1 = 0; m_v2 = 0;
            m_s1l = 0; m_s1r = 0; m_p2l = 0; m_p2r = 0;
        end else begin
            sz = exp_q.size();
            check("out_valid", 32'(out_valid), 32'(sz != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            pop = 0;
            if (out_valid && out_ready) begin
                if (sz == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h_%h expected no output", out_l, out_r);
                end else begin
                    head = exp_q.pop_front();
                    check("out_pair", {out_l, out_r}, head);
                    pop = 1;
                end
            end
            drop = 0;
            if (m_v2) begin
                if (sz == 4 && !pop) drop = 1;
                else exp_q.push_back({ref_out(m_p2l, m_mute), ref_out(m_p2r, m_mute)});
            end
            m_v2  = m_v1;
            m_p2l = m_s1l * m_gl;
            m_p2r = m_s1r * m_gr;
            tick  = (m_cnt == m_per - 1);
            m_v1  = tick;
            if (tick) begin
                m_s1l = int'($signed(sample_l));
                m_s1r = int'($signed(sample_r));
            end
            if (mgmt_write && mgmt_address == 9'd258) begin
                m_per = (mgmt_writedata[10:0] < 11'd2) ? 2 : int'(mgmt_writedata[10:0]);
                m_cnt = 0;
            end else begin
                m_cnt = tick ? 0 : m_cnt + 1;
            end
            if (mgmt_write && mgmt_address == 9'd259) begin
                m_gl   = int'(mgmt_writedata[7:0]);
                m_gr   = int'(mgmt_writedata[15:8]);
                m_mute = mgmt_writedata[16];
            end
            if (drop) m_ovf = 1;
            else if (mgmt_write && mgmt_address == 9'd260) m_ovf = 0;
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic mgmt_wr(logic [8:0] addr, logic [31:0] data);
        @(posedge clk);
        #2;
        mgmt_address   = addr;
        mgmt_writedata = data;
        mgmt_write     = 1'b1;
        @(posedge clk);
        #2;
        mgmt_write     = 1'b0;
    endtask

    // Rising edges from reset release until out_valid first appears.
    task automatic check_latency(string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < 1200 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = out_valid;
        end
        check(name, seen ? 32'(n) : 32'hFFFF_FFFF, 32'd1044);
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k == 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries expected 0", exp_q.size());
        end
    endtask

    initial begin
        int k;
        sample_l  = 16'h1234;
        sample_r  = 16'hEDCC;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_l", 32'(out_l), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        check_latency("first_valid_latency");
        wait_cycles(2200);
        check("unity_out_l", 32'(out_l), 32'h1234);
        check("unity_out_r", 32'(out_r), 32'hEDCC);

        mgmt_wr(9'd258, 32'd20);
        sample_l = 16'h7000;
        sample_r = 16'h8000;
        mgmt_wr(9'd259, 32'h0000FFFF);
        wait_cycles(100);
        check("sat_out_l", 32'(out_l), 32'h7FFF);
        check("sat_out_r", 32'(out_r), 32'h8000);

        sample_l = 16'hFFFE;
        sample_r = 16'h0003;
        mgmt_wr(9'd259, 32'h00004040);
        wait_cycles(100);
        check("half_out_l", 32'(out_l), 32'hFFFF);
        check("half_out_r", 32'(out_r), 32'h0001);

        sample_l = 16'h4321;
        sample_r = 16'hC000;
        mgmt_wr(9'd259, 32'h00010080);
        wait_cycles(100);
        check("mute_out_l", 32'(out_l), 32'h0);
        check("mute_out_r", 32'(out_r), 32'h0);
        mgmt_wr(9'd259, 32'h00000080);
        wait_cycles(100);
        check("unmute_out_l", 32'(out_l), 32'h4321);

        for (int i = 0; i < 800; i++) begin
            sample_l  = 16'($urandom);
            sample_r  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                mgmt_write = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin mgmt_address = 9'd258; mgmt_writedata = $urandom_range(0, 9); end
                    1: begin mgmt_address = 9'd259;
                             mgmt_writedata = {15'b0, 1'($urandom_range(0, 3) == 0), 16'($urandom)}; end
                    2: begin mgmt_address = 9'd260; mgmt_writedata = $urandom; end
                    default: begin mgmt_address = 9'($urandom_range(261, 511)); mgmt_writedata = $urandom; end
                endcase
            end else begin
                mgmt_write = 1'b0;
            end
            @(posedge clk);
            #2;
        end
        mgmt_write = 1'b0;

        out_ready = 1'b1;
        mgmt_wr(9'd259, 32'h00000080);
        mgmt_wr(9'd258, 32'd20);
        wait_empty();
        out_ready = 1'b0;
        mgmt_wr(9'd258, 32'd2);
        mgmt_wr(9'd260, 32'd0);
        for (int j = 0; j < 14; j++) begin
            sample_l = 16'(j * 3 + 1);
            sample_r = 16'(-j);
            @(posedge clk);
            #2;
        end
        check("overflow_set", 32'(overflow), 32'h1);
        check("full_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        wait_cycles(20);
        mgmt_wr(9'd260, 32'd0);
        check("overflow_cleared", 32'(overflow), 32'h0);

        out_ready = 1'b0;
        k = 0;
        while (exp_q.size() != 3 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k == 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_three_timeout: got %0d entries expected 3", exp_q.size());
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        check("midrst_out_l", 32'(out_l), 32'h0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        sample_l  = 16'h1234;
        sample_r  = 16'hEDCC;
        out_ready = 1'b1;
        check_latency("latency_after_reset");
        wait_cycles(1100);
        check("restored_gain_l", 32'(out_l), 32'h1234);
        check("restored_gain_r", 32'(out_r), 32'hEDCC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
